// File: rtl/pulse_train_gen.sv
// pulse_train_gen: emits a burst of N rectangular pulses with programmable high/low phase lengths.
// Optional abort input is enabled by defining PULSE_TRAIN_ABORT_EN.
module pulse_train_gen #(
   parameter int COUNT_WIDTH = 32,
   parameter int TIME_WIDTH  = 16
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   start_in,
   input  logic [COUNT_WIDTH-1:0] count_in,
   input  logic [TIME_WIDTH-1:0]  high_in,
   input  logic [TIME_WIDTH-1:0]  low_in,
`ifdef PULSE_TRAIN_ABORT_EN
   input  logic                   abort_in,
`endif
   output logic                   signal_out,
   output logic                   busy_out,
   output logic                   done_out,
   output logic [COUNT_WIDTH-1:0] sent_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t                 state_r, state_s;
   logic [COUNT_WIDTH-1:0] count_r, count_s;
   logic [COUNT_WIDTH-1:0] sent_r, sent_s;
   logic [TIME_WIDTH-1:0]  high_r, high_s;
   logic [TIME_WIDTH-1:0]  low_r, low_s;
   logic [TIME_WIDTH-1:0]  phase_r, phase_s;
   logic                   signal_r, signal_s;
   logic                   busy_r, busy_s;
   logic                   done_r, done_s;
   logic                   abort_s;

`ifdef PULSE_TRAIN_ABORT_EN
   assign abort_s = abort_in;
`else
   assign abort_s = 1'b0;
`endif

   // Next-state and next-output logic; outputs are computed here and registered below.
   always_comb begin
      state_s  = state_r;
      count_s  = count_r;
      high_s   = high_r;
      low_s    = low_r;
      phase_s  = phase_r;
      sent_s   = sent_r;
      signal_s = 1'b0;
      busy_s   = 1'b0;
      done_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (start_in) begin
               count_s = count_in;
               // Zero-length phases are stretched to one cycle so the countdown never wraps.
               high_s  = (high_in == {TIME_WIDTH{1'b0}}) ? TIME_WIDTH'(1) : high_in;
               low_s   = (low_in == {TIME_WIDTH{1'b0}}) ? TIME_WIDTH'(1) : low_in;
               sent_s  = {COUNT_WIDTH{1'b0}};
               if (count_in == {COUNT_WIDTH{1'b0}}) begin
                  state_s = DONE;
                  done_s  = 1'b1;
               end else begin
                  state_s  = HIGH;
                  signal_s = 1'b1;
                  busy_s   = 1'b1;
                  sent_s   = COUNT_WIDTH'(1);
                  phase_s  = high_s - TIME_WIDTH'(1);
               end
            end else begin
               state_s = IDLE;
            end
         end
         HIGH: begin
            if (abort_s) begin
               state_s = DONE;
               done_s  = 1'b1;
            end else if (phase_r == {TIME_WIDTH{1'b0}}) begin
               state_s = LOW;
               busy_s  = 1'b1;
               phase_s = low_r - TIME_WIDTH'(1);
            end else begin
               signal_s = 1'b1;
               busy_s   = 1'b1;
               phase_s  = phase_r - TIME_WIDTH'(1);
            end
         end
         LOW: begin
            if (abort_s) begin
               state_s = DONE;
               done_s  = 1'b1;
            end else if (phase_r == {TIME_WIDTH{1'b0}}) begin
               // sent_r counts pulses started, so the comparison cannot overflow at the max count.
               if (sent_r < count_r) begin
                  state_s  = HIGH;
                  signal_s = 1'b1;
                  busy_s   = 1'b1;
                  sent_s   = sent_r + COUNT_WIDTH'(1);
                  phase_s  = high_r - TIME_WIDTH'(1);
               end else begin
                  state_s = DONE;
                  done_s  = 1'b1;
               end
            end else begin
               busy_s  = 1'b1;
               phase_s = phase_r - TIME_WIDTH'(1);
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, configuration and output registers with synchronous reset.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_r  <= IDLE;
         count_r  <= {COUNT_WIDTH{1'b0}};
         sent_r   <= {COUNT_WIDTH{1'b0}};
         high_r   <= {TIME_WIDTH{1'b0}};
         low_r    <= {TIME_WIDTH{1'b0}};
         phase_r  <= {TIME_WIDTH{1'b0}};
         signal_r <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         count_r  <= count_s;
         sent_r   <= sent_s;
         high_r   <= high_s;
         low_r    <= low_s;
         phase_r  <= phase_s;
         signal_r <= signal_s;
         busy_r   <= busy_s;
         done_r   <= done_s;
      end
   end

   assign signal_out = signal_r;
   assign busy_out   = busy_r;
   assign done_out   = done_r;
   assign sent_out   = sent_r;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: directed and randomized bursts against a closed-form model.
// Define PULSE_TRAIN_ABORT_EN to also exercise the abort input.
module tb_pulse_train_gen;

   localparam int CW = 32;
   localparam int TW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          abort;
   logic [CW-1:0] cnt;
   logic [TW-1:0] hi;
   logic [TW-1:0] lo;
   logic          sig;
   logic          busy;
   logic          done;
   logic [CW-1:0] sent;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pulse_train_gen #(.COUNT_WIDTH(CW), .TIME_WIDTH(TW)) dut (
      .clk_in    (clk),
      .rst_in    (rst),
      .start_in  (start),
      .count_in  (cnt),
      .high_in   (hi),
      .low_in    (lo),
`ifdef PULSE_TRAIN_ABORT_EN
      .abort_in  (abort),
`endif
      .signal_out(sig),
      .busy_out  (busy),
      .done_out  (done),
      .sent_out  (sent)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic es, input logic eb, input logic ed,
                          input longint esent);
      chk({tag, ".signal"}, 64'(sig), 64'(es));
      chk({tag, ".busy"}, 64'(busy), 64'(eb));
      chk({tag, ".done"}, 64'(done), 64'(ed));
      chk({tag, ".sent"}, 64'(sent), 64'(esent));
   endtask

   // Model: k cycles after the accepted start edge, with period p = H+L and done at cycle kd.
   task automatic chk_model(input string tag, input longint k, input longint he, input longint p,
                            input longint kd, input longint sfin);
      if (k < kd)
         chk_all(tag, ((k - 1) % p) < he, 1'b1, 1'b0, (k - 1) / p + 1);
      else if (k == kd)
         chk_all(tag, 1'b0, 1'b0, 1'b1, sfin);
      else
         chk_all(tag, 1'b0, 1'b0, 1'b0, sfin);
   endtask

   // Entry/exit point: #1 after a rising edge. ka>0 asserts abort while cycle ka is observed.
   task automatic burst(input string tag, input longint n, input longint h, input longint l,
                        input longint ka, input bit noise);
      longint he, le, p, kd, sfin;
      he   = (h == 0) ? 1 : h;
      le   = (l == 0) ? 1 : l;
      p    = he + le;
      kd   = (ka > 0) ? ka + 1 : n * p + 1;
      sfin = (n == 0) ? 0 : ((ka > 0) ? (ka - 1) / p + 1 : n);
      start = 1'b1;
      cnt   = CW'(n);
      hi    = TW'(h);
      lo    = TW'(l);
      for (longint k = 1; k <= kd + 1; k++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         abort = 1'b0;
         chk_model(tag, k, he, p, kd, sfin);
         if (k == ka) abort = 1'b1;
         if (noise && k < kd) begin
            start = 1'($urandom_range(0, 1));
            cnt   = CW'($urandom_range(1, 20));
            hi    = TW'($urandom);
            lo    = TW'($urandom);
         end
      end
   endtask

   initial begin
      longint n, h, l;
      rst   = 1'b1;
      start = 1'b1;
      abort = 1'b0;
      cnt   = CW'(3);
      hi    = TW'(2);
      lo    = TW'(3);

      // Reset held with a concurrent start: reset wins, then 20 idle cycles.
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         chk_all("reset", 1'b0, 1'b0, 1'b0, 0);
      end
      rst   = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         chk_all("idle", 1'b0, 1'b0, 1'b0, 0);
      end

      burst("basic", 3, 2, 3, 0, 1'b0);
      burst("n0", 0, 5, 5, 0, 1'b0);
      burst("h0l0", 2, 0, 0, 0, 1'b0);
      burst("ignore", 4, 1, 1, 0, 1'b1);

      // Reset during the 3rd high phase (cycles 21..25 of a 10-cycle period).
      start = 1'b1;
      cnt   = CW'(10);
      hi    = TW'(5);
      lo    = TW'(5);
      for (longint k = 1; k <= 22; k++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         chk_model("midrst", k, 5, 10, 101, 10);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk_all("midrst.after", 1'b0, 1'b0, 1'b0, 0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk_all("midrst.quiet", 1'b0, 1'b0, 1'b0, 0);
      end
      burst("postrst", 1, 1, 1, 0, 1'b0);

`ifdef PULSE_TRAIN_ABORT_EN
      burst("abort", 5, 4, 4, 10, 1'b0);
      burst("abort_low", 3, 2, 2, 7, 1'b0);
      burst("abort_end", 2, 1, 2, 6, 1'b0);
`endif

      for (int i = 0; i < 12; i++) begin
         n = longint'($urandom_range(0, 5));
         h = longint'($urandom_range(0, 4));
         l = longint'($urandom_range(0, 4));
         burst("rand", n, h, l, 0, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
